fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV64 pipeline, directly upstream of decode.
- Owns the PC register and a request/response handshake to instruction memory, which may have variable latency.
- Owns the IF/ID pipeline register that drives decode's current_instruction, addr_current_instruction and addr_next_instruction.
- Handles stall, flush and branch/jump redirect from the hazard unit and execute stage.

Parameters:
- RESET_PC, 64'h0000000000000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) placed in IF/ID on reset and flush.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall_fetch  in  1  hold PC and IF/ID contents.
- flush_decode  in  1  replace IF/ID with a bubble.
- pc_src  in  1  redirect fetch to pc_target.
- pc_target  in  64  redirect address.
- imem_req  out  1  fetch request valid.
- imem_addr  out  64  fetch address.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  fetched instruction.
- current_instruction  out  32  IF/ID instruction, to decode.
- addr_current_instruction  out  64  IF/ID PC.
- addr_next_instruction  out  64  IF/ID PC+4.
- instr_valid  out  1  IF/ID holds a real instruction (not a bubble).

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-high.
- Reset values: pc=RESET_PC; state=REQ; current_instruction=NOP_INSTR; addr_current_instruction=0; addr_next_instruction=0; instr_valid=0; hold buffer cleared. imem_req is 0 while reset is high.
- At most one outstanding memory request. The memory returns exactly one rvalid per accepted request, in order, no earlier than the cycle after acceptance.
- REQ state:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 -> WAIT.
  - pc_src before acceptance: pc<=pc_target, stay REQ. The address may change while not yet accepted.
  - pc_src and imem_ready in the same cycle: the old address is accepted, pc<=pc_target, -> DRAIN.
- WAIT state (imem_req=0), on imem_rvalid:
  - pc_src=1: drop the data, pc<=pc_target, -> REQ.
  - flush_decode=1: IF/ID<=bubble, drop the data, pc unchanged (refetch), -> REQ.
  - stall_fetch=1: capture imem_rdata into the hold buffer, -> HOLD.
  - Otherwise: IF/ID<={imem_rdata, pc, pc+4}, instr_valid<=1, pc<=pc+4, -> REQ.
- WAIT state with pc_src and no rvalid: pc<=pc_target, -> DRAIN.
- DRAIN state (imem_req=0):
  - Discard the next rvalid, -> REQ.
  - pc_src while in DRAIN updates pc only.
- HOLD state (imem_req=0):
  - stall_fetch=0: IF/ID<=hold buffer with pc, pc+4; instr_valid<=1; pc<=pc+4; -> REQ.
  - pc_src or flush_decode in HOLD: discard the hold buffer, apply the redirect or flush, -> REQ.
- IF/ID update priority, highest first: reset > flush_decode (bubble: NOP_INSTR, addresses unchanged, instr_valid=0) > stall_fetch (hold) > load.
  - flush_decode with no response still bubbles IF/ID.
  - stall_fetch alone never alters IF/ID or pc, except that pc_src always updates pc.
- Redirect priority: pc_src overrides stall_fetch for the PC.
- Arithmetic:
  - pc+4 is 64-bit modulo; 64'hFFFFFFFFFFFFFFFC wraps to 0.
  - pc_target[1:0] is forced to 2'b00 on load.
- Throughput: 1 instruction per 2 cycles when ready and rvalid are single-cycle. Latency from request acceptance to IF/ID valid is 1 cycle plus memory latency.
- Reset mid-transaction abandons the outstanding request. The memory model clears its pending response on reset as well.

Test Plan:
- Sequential fetch: reset, then memory with ready=1 and 1-cycle rvalid returns 32'h00a00513, 32'h00b00593 -> IF/ID shows (00a00513, 0, 4) then (00b00593, 4, 8), with instr_valid=1 and imem_addr stepping 0,4,8.
- Stall: assert stall_fetch when rvalid returns 32'h00c00613 at pc=8, hold 3 cycles -> IF/ID unchanged and imem_req=0 while stalled; one cycle after release IF/ID=(00c00613, 8, 12) and imem_addr=12.
- Redirect in WAIT: pc_src=1 with pc_target=64'h100 while a response is pending -> the next rvalid is discarded, instr_valid stays as before, next imem_addr=64'h100, and the following IF/ID shows addr 0x100 / 0x104.
- Flush with simultaneous response: flush_decode=1 and rvalid in the same cycle at pc=0x10 -> IF/ID=NOP_INSTR with instr_valid=0; refetch with imem_addr=0x10.
- Backpressure and wrap: imem_ready low for 4 cycles -> imem_req and imem_addr held stable. Redirect to 64'hFFFFFFFFFFFFFFFC -> addr_next_instruction=0 and the next fetch address is 0.
- Async reset mid-WAIT: assert reset between clock edges -> outputs immediately at reset values; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV64 instruction fetch. Owns the PC, a single-outstanding
//               request/response port to instruction memory and the IF/ID
//               register feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000000000000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_fetch,
    input  logic        flush_decode,
    input  logic        pc_src,
    input  logic [63:0] pc_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] current_instruction,
    output logic [63:0] addr_current_instruction,
    output logic [63:0] addr_next_instruction,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] w_pc_nxt;
    logic [63:0] w_pc_plus4;
    logic [63:0] w_target;
    logic [31:0] r_hold;
    logic [31:0] w_hold_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [63:0] r_addr_cur;
    logic [63:0] w_addr_cur_nxt;
    logic [63:0] r_addr_next;
    logic [63:0] w_addr_next_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        w_load;
    logic [31:0] w_load_instr;

    assign w_pc_plus4 = r_pc + 64'd4;
    assign w_target   = pc_target & ~64'h3;

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_hold_nxt   = r_hold;
        w_load       = 1'b0;
        w_load_instr = r_hold;
        case (r_state)
            S_REQ: begin
                if (pc_src) begin
                    w_pc_nxt = w_target;
                end
                // A redirect coinciding with acceptance leaves a stale response to drop.
                if (imem_ready) begin
                    w_state_nxt = pc_src ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                    if (pc_src) begin
                        w_pc_nxt = w_target;
                    end else if (flush_decode) begin
                        w_pc_nxt = r_pc;
                    end else if (stall_fetch) begin
                        w_hold_nxt  = imem_rdata;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_load       = 1'b1;
                        w_load_instr = imem_rdata;
                        w_pc_nxt     = w_pc_plus4;
                    end
                end else if (pc_src) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pc_src) begin
                    w_pc_nxt = w_target;
                end
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (pc_src) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (flush_decode) begin
                    w_state_nxt = S_REQ;
                end else if (!stall_fetch) begin
                    w_load      = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // Flush wins over any load; addresses are kept so decode still sees a PC.
    always_comb begin
        w_instr_nxt     = r_instr;
        w_addr_cur_nxt  = r_addr_cur;
        w_addr_next_nxt = r_addr_next;
        w_valid_nxt     = r_valid;
        if (flush_decode) begin
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_instr_nxt     = w_load_instr;
            w_addr_cur_nxt  = r_pc;
            w_addr_next_nxt = w_pc_plus4;
            w_valid_nxt     = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_hold      <= 32'd0;
            r_instr     <= NOP_INSTR;
            r_addr_cur  <= 64'd0;
            r_addr_next <= 64'd0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_hold      <= w_hold_nxt;
            r_instr     <= w_instr_nxt;
            r_addr_cur  <= w_addr_cur_nxt;
            r_addr_next <= w_addr_next_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    assign imem_req                 = (r_state == S_REQ) && !reset;
    assign imem_addr                = r_pc;
    assign current_instruction      = r_instr;
    assign addr_current_instruction = r_addr_cur;
    assign addr_next_instruction    = r_addr_next;
    assign instr_valid              = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Randomized scoreboard bench for fetch_stage with a
//               variable-latency memory and a transaction-level fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall_fetch = 1'b0;
    logic        flush_decode = 1'b0;
    logic        pc_src = 1'b0;
    logic [63:0] pc_target = 64'd0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] current_instruction;
    logic [63:0] addr_current_instruction;
    logic [63:0] addr_next_instruction;
    logic        instr_valid;

    fetch_stage #(
        .RESET_PC (64'h0000000000000000),
        .NOP_INSTR(NOP)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .stall_fetch             (stall_fetch),
        .flush_decode            (flush_decode),
        .pc_src                  (pc_src),
        .pc_target               (pc_target),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ready              (imem_ready),
        .imem_rvalid             (imem_rvalid),
        .imem_rdata              (imem_rdata),
        .current_instruction     (current_instruction),
        .addr_current_instruction(addr_current_instruction),
        .addr_next_instruction   (addr_next_instruction),
        .instr_valid             (instr_valid)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] ins;
        logic [63:0] a;
        logic [63:0] n;
        logic        v;
    } ifid_t;

    int          n_checks = 0;
    int          n_errors = 0;
    ifid_t       exp_q[$];
    logic [63:0] acc_q[$];
    logic [31:0] preset[$];
    bit          mon_en = 1'b0;
    ifid_t       mon_prev;

    // Reference model: fetch seen as transactions (in-flight, stale, held).
    logic [63:0] m_pc;
    bit          m_busy, m_stale, m_held;
    logic [31:0] m_hold;
    ifid_t       m_ifid;

    // Memory: one pending response with a countdown.
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic model_step();
        logic [63:0] tgt;
        ifid_t       nx;
        tgt = pc_target & ~64'h3;
        nx  = m_ifid;
        if (flush_decode) begin
            nx.ins = NOP;
            nx.v   = 1'b0;
        end
        if (!m_busy && !m_held) begin
            if (imem_ready) begin
                acc_q.push_back(m_pc);
                m_busy  = 1'b1;
                m_stale = pc_src;
            end
            if (pc_src) m_pc = tgt;
        end else if (m_held) begin
            if (pc_src) begin
                m_pc   = tgt;
                m_held = 1'b0;
            end else if (flush_decode) begin
                m_held = 1'b0;
            end else if (!stall_fetch) begin
                nx     = {m_hold, m_pc, m_pc + 64'd4, 1'b1};
                m_pc   = m_pc + 64'd4;
                m_held = 1'b0;
            end
        end else if (imem_rvalid) begin
            m_busy = 1'b0;
            if (pc_src) begin
                m_pc = tgt;
            end else if (!m_stale && !flush_decode) begin
                if (stall_fetch) begin
                    m_held = 1'b1;
                    m_hold = imem_rdata;
                end else begin
                    nx   = {imem_rdata, m_pc, m_pc + 64'd4, 1'b1};
                    m_pc = m_pc + 64'd4;
                end
            end
        end else if (pc_src) begin
            m_pc    = tgt;
            m_stale = 1'b1;
        end
        if (nx !== m_ifid) exp_q.push_back(nx);
        m_ifid = nx;
    endtask

    task automatic drive_cycle(input int p_ready, input int p_stall, input int p_flush,
                               input int p_src, input int max_lat);
        bit cur_req;
        @(negedge clock);
        cur_req     = imem_req;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data;
                mem_pend    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        imem_ready = ($urandom_range(99) < p_ready);
        if (cur_req && imem_ready && !mem_pend) begin
            mem_pend = 1'b1;
            mem_cnt  = int'($urandom_range(max_lat - 1));
            mem_data = (preset.size() > 0) ? preset.pop_front() : $urandom;
        end
        stall_fetch  = ($urandom_range(99) < p_stall);
        flush_decode = ($urandom_range(99) < p_flush);
        pc_src       = ($urandom_range(99) < p_src);
        case ($urandom_range(3))
            0: pc_target = 64'h100;
            1: pc_target = 64'hFFFFFFFFFFFFFFFC;
            2: pc_target = {32'd0, $urandom};
            default: pc_target = {$urandom, $urandom};
        endcase
        model_step();
    endtask

    // Monitor: compares whenever the DUT accepts a fetch or IF/ID changes.
    always begin
        ifid_t cur;
        ifid_t e;
        @(negedge clock);
        #2;
        if (mon_en) begin
            cur = {current_instruction, addr_current_instruction, addr_next_instruction, instr_valid};
            if (imem_req && imem_ready) begin
                if (acc_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_accept: got addr %h, expected no request", imem_addr);
                end else begin
                    check("fetch_addr", imem_addr, acc_q.pop_front());
                end
            end
            if (cur !== mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ifid: got %h/%h/%h/%b, expected no change",
                             cur.ins, cur.a, cur.n, cur.v);
                end else begin
                    e = exp_q.pop_front();
                    check("ifid_instr", 64'(cur.ins), 64'(e.ins));
                    check("ifid_addr_cur", cur.a, e.a);
                    check("ifid_addr_next", cur.n, e.n);
                    check("ifid_valid", 64'(cur.v), 64'(e.v));
                end
                mon_prev = cur;
            end
        end
    end

    initial begin
        bit found;
        preset.push_back(32'h00a00513);
        preset.push_back(32'h00b00593);
        repeat (2) @(negedge clock);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_instr", 64'(current_instruction), 64'(NOP));
        check("rst_addr_cur", addr_current_instruction, 64'd0);
        check("rst_addr_next", addr_next_instruction, 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        reset = 1'b0;
        #2;
        check("post_rst_req", 64'(imem_req), 64'd1);
        check("post_rst_addr", imem_addr, 64'd0);

        m_pc     = 64'd0;
        m_busy   = 1'b0;
        m_stale  = 1'b0;
        m_held   = 1'b0;
        m_hold   = 32'd0;
        m_ifid   = {NOP, 64'd0, 64'd0, 1'b0};
        mon_prev = m_ifid;
        mon_en   = 1'b1;

        repeat (10)   drive_cycle(100, 0, 0, 0, 1);
        repeat (3000) drive_cycle(70, 25, 8, 8, 3);
        repeat (30)   drive_cycle(100, 0, 0, 0, 1);

        @(negedge clock);
        imem_ready   = 1'b0;
        imem_rvalid  = 1'b0;
        stall_fetch  = 1'b0;
        flush_decode = 1'b0;
        pc_src       = 1'b0;
        #3;
        mon_en = 1'b0;
        check("ifid_leftover", 64'(exp_q.size()), 64'd0);
        check("accept_leftover", 64'(acc_q.size()), 64'd0);

        // Reach WAIT with a real instruction in IF/ID, then reset between edges.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            imem_rvalid = mem_pend;
            imem_rdata  = mem_data;
            mem_pend    = 1'b0;
            imem_ready  = 1'b1;
            if (imem_req) found = 1'b1;
        end
        check("reach_wait", 64'(found), 64'd1);
        @(posedge clock);
        #2;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        check("pre_reset_valid", 64'(instr_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("async_req", 64'(imem_req), 64'd0);
        check("async_instr", 64'(current_instruction), 64'(NOP));
        check("async_addr_cur", addr_current_instruction, 64'd0);
        check("async_addr_next", addr_next_instruction, 64'd0);
        check("async_valid", 64'(instr_valid), 64'd0);
        check("async_pc", imem_addr, 64'd0);
        mem_pend = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #2;
        check("release_req", 64'(imem_req), 64'd1);
        check("release_addr", imem_addr, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
